// File: rtl/br_redirect_if.sv
// Purpose : bundles the EX0 branch-result inputs, the fetch redirect handshake and
//           the statistics outputs of br_redirect into one port.
// Ports   : resvld_ex0/br_tgt_ex0/mispred_ex0 (EX0 result), redirect_rdy (fetch ready);
//           redirect_vld/redirect_tgt (redirect request), flush_ex1, wrongpath_ex0,
//           br_cnt/mispred_cnt (saturating statistics).
//           slave = br_redirect side, master = pipe/fetch side.
interface br_redirect_if #(
   parameter int unsigned CNT_W = 32
);
   logic              resvld_ex0;
   logic [31:0]       br_tgt_ex0;
   logic              mispred_ex0;
   logic              redirect_rdy;
   logic              redirect_vld;
   logic [31:0]       redirect_tgt;
   logic              flush_ex1;
   logic              wrongpath_ex0;
   logic [CNT_W-1:0]  br_cnt;
   logic [CNT_W-1:0]  mispred_cnt;

   modport slave (
      input  resvld_ex0, br_tgt_ex0, mispred_ex0, redirect_rdy,
      output redirect_vld, redirect_tgt, flush_ex1, wrongpath_ex0, br_cnt, mispred_cnt
   );

   modport master (
      output resvld_ex0, br_tgt_ex0, mispred_ex0, redirect_rdy,
      input  redirect_vld, redirect_tgt, flush_ex1, wrongpath_ex0, br_cnt, mispred_cnt
   );
endinterface

// File: rtl/br_redirect.sv
// Purpose : registers an EX0 branch mispredict into a held fetch redirect plus a one-cycle
//           EX1 flush, squashes wrong-path results until fetch has drained, counts branches.
// Latency : EX0 mispredict at edge N -> redirect_vld and flush_ex1 during cycle N+1.
// Backpr. : redirect_vld/redirect_tgt held until redirect_rdy is sampled; one redirect
//           outstanding, every EX0 result seen while it is pending or draining is dropped.
// Ports   : clk, reset (sync, active-low), br (br_redirect_if.slave).
module br_redirect #(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned CNT_W        = 32
) (
   input  logic           clk,
   input  logic           reset,
   br_redirect_if.slave   br
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [3:0]       DRAIN_LD = 4'(DRAIN_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [3:0]        drain_cnt_q, drain_cnt_d;
   logic [31:0]       tgt_q, tgt_d;
   logic              flush_q, flush_d;
   logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;

   logic              wrongpath;
   logic              acc_ex0;
   logic              mis_ex0;

   // flush_q only ever rides with the first REQ cycle, so it is already covered by
   // state != IDLE; it is kept in the term so the squash does not depend on that.
   assign wrongpath = (state_q != IDLE) | flush_q;
   assign acc_ex0   = br.resvld_ex0 & ~wrongpath;
   assign mis_ex0   = acc_ex0 & br.mispred_ex0;

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      tgt_d       = tgt_q;
      flush_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (mis_ex0) begin
               tgt_d   = br.br_tgt_ex0;
               flush_d = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (br.redirect_rdy) begin
               if (DRAIN_LD == 4'd0) begin
                  state_d = IDLE;
               end else begin
                  drain_cnt_d = DRAIN_LD;
                  state_d     = DRAIN;
               end
            end
         end
         DRAIN: begin
            drain_cnt_d = drain_cnt_q - 4'd1;
            // <= 1 rather than == 1 so a corrupted zero count cannot wedge the FSM
            if (drain_cnt_q <= 4'd1) begin
               drain_cnt_d = 4'd0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            drain_cnt_d = 4'd0;
         end
      endcase
   end

   // Saturating statistics: hold at all-ones
   always_comb begin
      br_cnt_d  = br_cnt_q;
      mis_cnt_d = mis_cnt_q;
      if (acc_ex0 && (br_cnt_q != '1)) begin
         br_cnt_d = br_cnt_q + CNT_ONE;
      end
      if (mis_ex0 && (mis_cnt_q != '1)) begin
         mis_cnt_d = mis_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         drain_cnt_q <= 4'd0;
         tgt_q       <= 32'd0;
         flush_q     <= 1'b0;
         br_cnt_q    <= '0;
         mis_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         tgt_q       <= tgt_d;
         flush_q     <= flush_d;
         br_cnt_q    <= br_cnt_d;
         mis_cnt_q   <= mis_cnt_d;
      end
   end

   assign br.redirect_vld  = (state_q == REQ);
   assign br.redirect_tgt  = tgt_q;
   assign br.flush_ex1     = flush_q;
   assign br.wrongpath_ex0 = wrongpath;
   assign br.br_cnt        = br_cnt_q;
   assign br.mispred_cnt   = mis_cnt_q;

endmodule

// File: tb/tb_br_redirect.sv
// Purpose : checks br_redirect (two configurations) against a timeline reference model
//           over directed scenarios followed by random traffic.
// Latency : n/a (testbench).
// Backpr. : n/a (testbench drives redirect_rdy directly).
module tb_br_redirect;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_vld, in_mis, in_rdy;
   logic [31:0] in_tgt;

   always #5 clk = ~clk;

   br_redirect_if #(.CNT_W(32)) bif_a ();
   br_redirect_if #(.CNT_W(4))  bif_b ();

   assign bif_a.resvld_ex0   = in_vld;
   assign bif_a.mispred_ex0  = in_mis;
   assign bif_a.br_tgt_ex0   = in_tgt;
   assign bif_a.redirect_rdy = in_rdy;
   assign bif_b.resvld_ex0   = in_vld;
   assign bif_b.mispred_ex0  = in_mis;
   assign bif_b.br_tgt_ex0   = in_tgt;
   assign bif_b.redirect_rdy = in_rdy;

   br_redirect #(.DRAIN_CYCLES(3), .CNT_W(32)) u_dut_a (.clk(clk), .reset(reset), .br(bif_a));
   br_redirect #(.DRAIN_CYCLES(0), .CNT_W(4))  u_dut_b (.clk(clk), .reset(reset), .br(bif_b));

   int n_err = 0;
   int n_chk = 0;
   int cyc   = 0;

   // Reference model: a redirect is pending from the cycle after the accepted mispredict
   // until the handshake cycle; results are squashed while it is pending and for
   // DRAIN_CYCLES cycles after the handshake cycle.
   int          drain_of [2] = '{3, 0};
   longint      sat_of   [2] = '{64'hFFFF_FFFF, 64'd15};
   bit          m_req    [2];
   logic [31:0] m_tgt    [2];
   int          m_flush  [2];
   int          m_sq_end [2];
   longint      m_br     [2];
   longint      m_mis    [2];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic longint sat(input longint v, input longint lim);
      return (v > lim) ? lim : v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_req[i] = 1'b0; m_tgt[i] = 32'd0; m_flush[i] = -1; m_sq_end[i] = -1;
         m_br[i] = 0; m_mis[i] = 0;
      end
   endtask

   task automatic compare_outputs();
      logic [63:0] o_vld, o_tgt, o_fl, o_wp, o_br, o_mis;
      bit          wp;
      for (int i = 0; i < 2; i++) begin
         if (i == 0) begin
            o_vld = 64'(bif_a.redirect_vld); o_tgt = 64'(bif_a.redirect_tgt);
            o_fl = 64'(bif_a.flush_ex1); o_wp = 64'(bif_a.wrongpath_ex0);
            o_br = 64'(bif_a.br_cnt); o_mis = 64'(bif_a.mispred_cnt);
         end else begin
            o_vld = 64'(bif_b.redirect_vld); o_tgt = 64'(bif_b.redirect_tgt);
            o_fl = 64'(bif_b.flush_ex1); o_wp = 64'(bif_b.wrongpath_ex0);
            o_br = 64'(bif_b.br_cnt); o_mis = 64'(bif_b.mispred_cnt);
         end
         wp = m_req[i] || (cyc <= m_sq_end[i]);
         check_eq($sformatf("redirect_vld[%0d]", i), o_vld, 64'(m_req[i]));
         check_eq($sformatf("redirect_tgt[%0d]", i), o_tgt, 64'(m_tgt[i]));
         check_eq($sformatf("flush_ex1[%0d]", i), o_fl, 64'(cyc == m_flush[i]));
         check_eq($sformatf("wrongpath[%0d]", i), o_wp, 64'(wp));
         check_eq($sformatf("br_cnt[%0d]", i), o_br, 64'(sat(m_br[i], sat_of[i])));
         check_eq($sformatf("mispred_cnt[%0d]", i), o_mis, 64'(sat(m_mis[i], sat_of[i])));
      end
   endtask

   task automatic model_edge(input bit rst_n, input bit vld, input bit mis,
                             input logic [31:0] tgt, input bit rdy);
      bit wp, acc;
      if (!rst_n) begin
         model_reset();
      end else begin
         for (int i = 0; i < 2; i++) begin
            wp  = m_req[i] || (cyc <= m_sq_end[i]);
            acc = vld && !wp;
            if (acc) m_br[i]++;
            if (acc && mis) begin
               m_mis[i]++;
               m_req[i]   = 1'b1;
               m_tgt[i]   = tgt;
               m_flush[i] = cyc + 1;
            end else if (m_req[i] && rdy) begin
               m_req[i]    = 1'b0;
               m_sq_end[i] = cyc + drain_of[i];
            end
         end
      end
   endtask

   // One clock cycle: apply inputs, check outputs mid-cycle, advance model at the edge.
   task automatic step(input bit rst_n, input bit vld, input bit mis,
                       input logic [31:0] tgt, input bit rdy);
      reset  = rst_n;
      in_vld = vld;
      in_mis = mis;
      in_tgt = tgt;
      in_rdy = rdy;
      @(negedge clk);
      compare_outputs();
      @(posedge clk);
      model_edge(rst_n, vld, mis, tgt, rdy);
      cyc++;
      #1;
   endtask

   initial begin
      int n_vld, n_fl;
      logic [63:0] br_snap, mis_snap;

      reset = 1'b0; in_vld = 1'b1; in_mis = 1'b1; in_tgt = 32'hDEAD_BEEF; in_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();

      // Reset held with a valid mispredict: outputs stay 0
      step(0, 1, 1, 32'hDEAD_BEEF, 0);
      step(0, 1, 1, 32'hDEAD_BEEF, 0);
      // Release, mispredict to 0x1000 is taken
      step(1, 1, 1, 32'h0000_1000, 0);
      check_eq("post_rst_vld", 64'(bif_a.redirect_vld), 64'd1);
      check_eq("post_rst_tgt", 64'(bif_a.redirect_tgt), 64'h1000);
      step(1, 0, 0, 32'd0, 1);
      repeat (5) step(1, 0, 0, 32'd0, 0);

      // Single mispredict, fetch stalls 5 cycles
      step(0, 0, 0, 32'd0, 0);
      step(1, 1, 1, 32'h8000_0040, 0);
      n_vld = 0; n_fl = 0;
      for (int k = 0; k < 7; k++) begin
         n_vld += int'(bif_a.redirect_vld);
         n_fl  += int'(bif_a.flush_ex1);
         step(1, 0, 0, 32'd0, k == 5);
      end
      check_eq("stall_vld_cycles", 64'(n_vld), 64'd6);
      check_eq("stall_flush_pulses", 64'(n_fl), 64'd1);
      repeat (4) step(1, 0, 0, 32'd0, 0);
      check_eq("stall_mis_cnt", 64'(bif_a.mispred_cnt), 64'd1);
      check_eq("stall_br_cnt", 64'(bif_a.br_cnt), 64'd1);

      // Zero-wait fetch, back-to-back correct branches after a mispredict
      step(0, 0, 0, 32'd0, 0);
      step(1, 1, 1, 32'h40, 1);
      repeat (5) step(1, 1, 0, 32'h44, 1);
      check_eq("drain_br_cnt_a", 64'(bif_a.br_cnt), 64'd2);
      check_eq("drain_br_cnt_b", 64'(bif_b.br_cnt), 64'd5);

      // Consecutive mispredicts: only the first redirects
      step(0, 0, 0, 32'd0, 0);
      step(1, 1, 1, 32'h100, 0);
      step(1, 1, 1, 32'h200, 0);
      step(1, 0, 0, 32'd0, 1);
      repeat (4) step(1, 0, 0, 32'd0, 0);
      check_eq("b2b_tgt", 64'(bif_a.redirect_tgt), 64'h100);
      check_eq("b2b_mis_cnt", 64'(bif_a.mispred_cnt), 64'd1);

      // mispred without resvld is ignored
      br_snap  = 64'(bif_a.br_cnt);
      mis_snap = 64'(bif_a.mispred_cnt);
      repeat (10) step(1, 0, 1, 32'h300, 1);
      check_eq("novld_br_cnt", 64'(bif_a.br_cnt), br_snap);
      check_eq("novld_mis_cnt", 64'(bif_a.mispred_cnt), mis_snap);
      check_eq("novld_redirect", 64'(bif_a.redirect_vld), 64'd0);

      // Saturation of the 4-bit counter
      step(0, 0, 0, 32'd0, 0);
      repeat (20) step(1, 1, 0, 32'h500, 0);
      check_eq("sat_br_cnt_b", 64'(bif_b.br_cnt), 64'd15);
      check_eq("sat_br_cnt_a", 64'(bif_a.br_cnt), 64'd20);

      // Reset while in REQ with redirect_rdy high
      step(1, 1, 1, 32'hABC, 0);
      step(0, 0, 0, 32'd0, 1);
      check_eq("rst_req_vld", 64'(bif_a.redirect_vld), 64'd0);
      check_eq("rst_req_idle", 64'(bif_a.wrongpath_ex0), 64'd0);
      step(1, 1, 0, 32'h600, 1);
      check_eq("rst_first_acc", 64'(bif_a.br_cnt), 64'd1);

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         step(($urandom_range(63) != 0),
              ($urandom_range(1) == 1),
              ($urandom_range(2) == 0),
              32'($urandom()),
              ($urandom_range(1) == 1));
      end
      step(1, 0, 0, 32'd0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/br_redirect.md
# br_redirect

Branch-resolution back end of the EX pipe. Takes the EX0 result of the integer branch unit (valid, true target, mispredict), registers it into EX1, and turns a qualified mispredict into a single held redirect request to fetch plus a one-cycle flush of younger stages. It then squashes wrong-path branch results until the front end has been redirected and drained, and keeps saturating branch and mispredict counters.

## Interface
- DRAIN_CYCLES, default 3: cycles after redirect acceptance during which arriving EX0 results are wrong-path (fetch-to-EX0 depth); legal range 0..15.
- CNT_W, default 32: width of the statistics counters.

- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low (asserted when 0, sampled on posedge clk).
- resvld_ex0  in  1  branch result valid in EX0.
- br_tgt_ex0  in  t_paddr (32)  resolved next PC of the branch.
- mispred_ex0  in  1  branch mispredicted; meaningful only with resvld_ex0.
- redirect_rdy  in  1  fetch accepts the redirect this cycle.
- redirect_vld  out  1  redirect request to fetch.
- redirect_tgt  out  t_paddr  fetch restart PC.
- flush_ex1  out  1  one-cycle kill of all stages younger than EX1.
- wrongpath_ex0  out  1  combinational; current EX0 result is squashed.
- br_cnt  out  CNT_W  non-squashed branches resolved, saturating.
- mispred_cnt  out  CNT_W  non-squashed mispredicts, saturating.

## Operation
- Qualified event: acc_ex0 = resvld_ex0 & !wrongpath_ex0; mis_ex0 = acc_ex0 & mispred_ex0.
- wrongpath_ex0 = (state != IDLE) | flush_ex1.
- FSM states:
  - IDLE: on mis_ex0, capture br_tgt_ex0 into redirect_tgt, go to REQ. Otherwise stay.
  - REQ: redirect_vld = 1 and redirect_tgt stays stable. On redirect_rdy, go to DRAIN and load drain_cnt = DRAIN_CYCLES; if DRAIN_CYCLES == 0, go to IDLE instead.
  - DRAIN: drain_cnt decrements each cycle. When drain_cnt == 1, go to IDLE on the next edge.
- flush_ex1 is 1 only in the first cycle of REQ, which is the cycle after the mispredicting branch sat in EX0.
- br_tgt_ex0 is used as-is; no alignment or arithmetic is applied.
- Counters:
  - br_cnt increments on acc_ex0.
  - mispred_cnt increments on mis_ex0.
  - Both hold at all-ones.
  - Squashed results never count.
- Only one redirect is outstanding. Any mispredict arriving in REQ or DRAIN is wrong-path by construction and is dropped.
- When reset is asserted:
  - The FSM goes to IDLE and drain_cnt clears.
  - redirect_vld, flush_ex1 and both counters go to 0.
  - redirect_tgt goes to 0.
  - This holds regardless of state, including mid-REQ with redirect_rdy high.

## Timing
- EX0 mispredict at edge N results in redirect_vld = 1 and flush_ex1 = 1 during cycle N+1.
- redirect_vld stays high until the cycle in which redirect_rdy = 1 is sampled. The handshake completes in that cycle and redirect_vld = 0 from the next cycle.
- redirect_rdy may be high while redirect_vld is low; this has no effect.
- Zero-wait fetch (redirect_rdy tied 1): REQ lasts 1 cycle, then DRAIN_CYCLES cycles of squash, then IDLE. The first EX0 result accepted is DRAIN_CYCLES+2 cycles after the mispredict.
- A correctly predicted branch in IDLE has no output effect beyond br_cnt incrementing next cycle.
- Back-to-back mispredicts in consecutive cycles: the first is taken, the second is squashed (wrongpath_ex0 = 1 through flush_ex1) and is not counted.
- Release of reset mid-stream: the first EX0 result in the cycle after reset is deasserted is accepted normally.

## Test plan
- Reset held low for 2 cycles with resvld_ex0 = 1 and mispred_ex0 = 1:
  - All outputs stay 0.
  - Release reset; the next mispredict with br_tgt_ex0 = 0x0000_1000 gives redirect_vld = 1 and redirect_tgt = 0x1000 one cycle later.
- Single mispredict to 0x8000_0040, redirect_rdy held 0 for 5 cycles then 1:
  - redirect_vld is high for 6 cycles with the target stable.
  - flush_ex1 pulses once.
  - mispred_cnt = 1 and br_cnt = 1.
- DRAIN_CYCLES = 3, redirect_rdy = 1, a mispredict followed by valid branches every cycle:
  - The 4 results arriving in REQ and DRAIN (REQ plus 3) are squashed.
  - The result arriving after DRAIN is counted.
  - br_cnt ends at 2.
- Mispredicts in two consecutive EX0 cycles (targets 0x100, 0x200):
  - Exactly one redirect is issued, to 0x100.
  - mispred_cnt = 1.
- resvld_ex0 = 0 with mispred_ex0 = 1 for 10 cycles: no redirect and no count change.
- CNT_W = 4, 20 correct branches: br_cnt saturates at 15 and holds.
- Reset asserted while in REQ: redirect_vld is 0 in the next cycle and the FSM is in IDLE.
